alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
// Sequential, parametrised ALU with valid/ready handshakes on command and result.
// Executes ADD/SUB/MUL in one cycle, DIV with an iterative radix-2 restoring divider, and MAC against an internal accumulator.
// Adds accumulator clear, divide-by-zero and illegal-opcode reporting, and output back-pressure.
// Sits between the command issue logic and the result writeback stage; exactly one operation is in flight at a time.
// PARAMETERS
// WIDTH    32  operand, result, remainder and accumulator width in bits (>=2)
// OP_W     3   opcode width
// PORTS
// clk          in   1      rising-edge clock
// reset_n      in   1      asynchronous active-low reset
// in_vld       in   1      command valid
// in_rdy       out  1      block can accept a command this cycle
// in_op        in   OP_W   opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MAC, 5 ACC_CLR, 6-7 illegal
// in_a         in   WIDTH  operand A (unsigned)
// in_b         in   WIDTH  operand B (unsigned)
// out_vld      out  1      result valid; held until accepted
// out_rdy      in   1      downstream accepts result
// out_data     out  WIDTH  result / quotient / new accumulator value
// out_rem      out  WIDTH  DIV remainder; 0 for all other ops
// out_err      out  1      divide-by-zero or illegal opcode
// acc_value    out  WIDTH  current accumulator contents
// BEHAVIOUR
// - Reset (async assert, sync deassert, handled by the reset source): state=IDLE; out_vld=0; out_data=0; out_rem=0; out_err=0; accumulator=0; in_rdy=1.
// - Command accepted on a cycle where in_vld & in_rdy are both high; operands and opcode are captured at that edge.
// - Result accepted on a cycle where out_vld & out_rdy are both high.
// - in_rdy = (state==IDLE) & (!out_vld | out_rdy); same-cycle result drain plus new accept is legal, with no bubble.
// - FSM states IDLE, DIV_RUN:
//   - IDLE --accept DIV, b!=0--> DIV_RUN.
//   - Any other accepted op stays in IDLE; its result is registered at the accept edge, so out_vld rises the next cycle (latency 1).
//   - DIV_RUN runs exactly WIDTH iteration cycles, one quotient bit per cycle, MSB first.
//   - On the edge ending the last iteration: out_vld=1, state=IDLE. DIV latency = WIDTH+1 cycles from accept to out_vld.
//   - in_rdy=0 throughout DIV_RUN.
// - Arithmetic (all modulo 2^WIDTH, unsigned; no carry/overflow output):
//   - ADD: a+b.
//   - SUB: a-b (wraps).
//   - MUL: low WIDTH bits of a*b.
//   - DIV: out_data=a/b, out_rem=a%b.
//   - MAC: acc <= acc + low(a*b) at the accept edge; out_data = new acc value.
//   - ACC_CLR: acc <= 0; out_data=0.
// - DIV with b==0: no DIV_RUN; latency 1; out_data=all ones, out_rem=a, out_err=1.
// - Illegal opcode: latency 1; out_data=0, out_rem=0, out_err=1; accumulator unchanged.
// - out_err=0 for every other result.
// - out_* remain stable while out_vld=1 & out_rdy=0; they update only on a new result.
// - Accumulator changes only on an accepted MAC or ACC_CLR; acc_value shows the registered accumulator, not a combinational value.
// - Back-pressure: while out_vld=1 & out_rdy=0, no command is accepted.
// - In DIV_RUN, the divider completes regardless of out_rdy, because out_vld was already 0 at accept.
// - Reset mid-DIV: divider state is discarded; no result is produced; accumulator returns to 0.
// TESTING (WIDTH=8 unless noted)
// 1 ADD a=200,b=100; SUB a=5,b=7; MUL a=16,b=17, back-to-back with out_rdy=1
//   -> out_data 44, 254, 16 on consecutive cycles, each 1 cycle after accept, err=0.
// 2 DIV a=200,b=7
//   -> in_rdy low 8 cycles; out_vld exactly 9 cycles after accept; out_data=28, out_rem=4.
//   DIV a=5,b=0 -> 1 cycle; out_data=255, out_rem=5, out_err=1.
// 3 ACC_CLR, then MAC (3,4), (10,10), (12,12)
//   -> out_data 0, 12, 112, 0 (256 wraps); acc_value tracks each value.
//   opcode 6 -> out_err=1, acc unchanged.
// 4 Hold out_rdy=0 for 5 cycles after an ADD
//   -> out_vld/out_data stable; in_rdy=0; a pending in_vld is not accepted.
//   Raise out_rdy -> same-cycle accept of the next command.
// 5 Assert reset_n=0 mid-DIV (cycle 4), release
//   -> out_vld=0 immediately (async); acc=0; in_rdy=1; no stale result afterwards.
// 6 WIDTH=32 random ADD/SUB/MUL/DIV/MAC stream with random out_rdy stalls vs. reference model
//   -> exact match, no lost or duplicated results.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential unsigned ALU: single-cycle ADD/SUB/MUL/MAC/ACC_CLR, iterative restoring DIV,
// valid/ready on both command and result, one operation in flight at a time.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_err,
  output logic [WIDTH-1:0] acc_value
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MAC = OP_W'(4);
  localparam logic [OP_W-1:0] OP_CLR = OP_W'(5);

  typedef enum logic {S_IDLE, S_DIV_RUN} state_t;

  state_t           r_state;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_out_rem;
  logic             r_out_err;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_div_start;
  logic [WIDTH-1:0] w_mul;
  logic [WIDTH-1:0] w_res_data;
  logic [WIDTH-1:0] w_res_rem;
  logic             w_res_err;
  logic             w_acc_we;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign in_rdy      = (r_state == S_IDLE) & (~r_out_vld | out_rdy);
  assign w_accept    = in_vld & in_rdy;
  assign w_div_start = (in_op == OP_DIV) & (in_b != '0);
  assign w_mul       = in_a * in_b;

  assign out_vld   = r_out_vld;
  assign out_data  = r_out_data;
  assign out_rem   = r_out_rem;
  assign out_err   = r_out_err;
  assign acc_value = r_acc;

  // One restoring step: r_quo shifts the dividend out of its MSB and the quotient in at its LSB.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};

  always_comb begin
    w_res_data = '0;
    w_res_rem  = '0;
    w_res_err  = 1'b0;
    w_acc_we   = 1'b0;
    w_acc_nxt  = r_acc;
    case (in_op)
      OP_ADD: w_res_data = in_a + in_b;
      OP_SUB: w_res_data = in_a - in_b;
      OP_MUL: w_res_data = w_mul;
      OP_DIV: begin
        w_res_data = '1;
        w_res_rem  = in_a;
        w_res_err  = 1'b1;
      end
      OP_MAC: begin
        w_acc_we   = 1'b1;
        w_acc_nxt  = r_acc + w_mul;
        w_res_data = w_acc_nxt;
      end
      OP_CLR: begin
        w_acc_we  = 1'b1;
        w_acc_nxt = '0;
      end
      default: w_res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_rem  <= '0;
      r_out_err  <= 1'b0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
    end else begin
      if (r_out_vld && out_rdy) r_out_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_div_start) begin
              r_state <= S_DIV_RUN;
              r_rem   <= '0;
              r_quo   <= in_a;
              r_div   <= in_b;
              r_cnt   <= LAST_IT;
            end else begin
              r_out_vld  <= 1'b1;
              r_out_data <= w_res_data;
              r_out_rem  <= w_res_rem;
              r_out_err  <= w_res_err;
              if (w_acc_we) r_acc <= w_acc_nxt;
            end
          end
        end
        S_DIV_RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
          // out_vld is already low here (in_rdy required it drained at accept), so no stall check.
          if (r_cnt == '0) begin
            r_state    <= S_IDLE;
            r_out_vld  <= 1'b1;
            r_out_data <= w_quo_nxt;
            r_out_rem  <= w_rem_nxt;
            r_out_err  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed WIDTH=8 cases plus a WIDTH=32 random stream against a queue model.
module tb_alu_seq;

  logic clk, rst_n;
  int   n_chk = 0, n_err = 0;

  // WIDTH=8 instance
  logic       vld8, rdy8, ovld8, ordy8, oerr8;
  logic [2:0] op8;
  logic [7:0] a8, b8, odata8, orem8, acc8;

  // WIDTH=32 instance
  logic        vld32, rdy32, ovld32, ordy32, oerr32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, odata32, orem32, acc32;

  alu_seq #(.WIDTH(8), .OP_W(3)) dut8 (
    .clk(clk), .reset_n(rst_n), .in_vld(vld8), .in_rdy(rdy8), .in_op(op8),
    .in_a(a8), .in_b(b8), .out_vld(ovld8), .out_rdy(ordy8), .out_data(odata8),
    .out_rem(orem8), .out_err(oerr8), .acc_value(acc8));

  alu_seq #(.WIDTH(32), .OP_W(3)) dut32 (
    .clk(clk), .reset_n(rst_n), .in_vld(vld32), .in_rdy(rdy32), .in_op(op32),
    .in_a(a32), .in_b(b32), .out_vld(ovld32), .out_rdy(ordy32), .out_data(odata32),
    .out_rem(orem32), .out_err(oerr32), .acc_value(acc32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present a command at the negedge, hold until ready, and return #1 after the accept edge.
  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    vld8 = 1'b1; op8 = op; a8 = a; b8 = b;
    #1;
    while (!rdy8 && w < 60) begin
      @(negedge clk); #1; w++;
    end
    chk("issue_rdy", 32'(rdy8), 1);
    @(posedge clk); #1;
    vld8 = 1'b0;
  endtask

  task automatic do1(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic [7:0] er, input logic ee);
    issue8(op, a, b);
    chk({tag, "_vld"},  32'(ovld8), 1);
    chk({tag, "_data"}, 32'(odata8), 32'(ed));
    chk({tag, "_rem"},  32'(orem8), 32'(er));
    chk({tag, "_err"},  32'(oerr8), 32'(ee));
  endtask

  // Reference model for the random stream
  typedef struct {
    logic [31:0] d;
    logic [31:0] r;
    logic [31:0] acc;
    logic        e;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_acc;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        x;
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    x.d = 0; x.r = 0; x.e = 1'b0;
    case (op)
      3'd0: x.d = a + b;
      3'd1: x.d = a - b;
      3'd2: x.d = p[31:0];
      3'd3: if (b == 0) begin x.d = 32'hFFFF_FFFF; x.r = a; x.e = 1'b1; end
            else begin x.d = a / b; x.r = a % b; end
      3'd4: begin m_acc = m_acc + p[31:0]; x.d = m_acc; end
      3'd5: m_acc = 0;
      default: x.e = 1'b1;
    endcase
    x.acc = m_acc;
    return x;
  endfunction

  initial begin
    int lat, low, stale, n_res;
    logic pend;
    exp_t x;

    rst_n = 1'b0;
    vld8 = 0; op8 = 0; a8 = 0; b8 = 0; ordy8 = 1'b1;
    vld32 = 0; op32 = 0; a32 = 0; b32 = 0; ordy32 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",  32'(ovld8), 0);
    chk("rst_data", 32'(odata8), 0);
    chk("rst_rem",  32'(orem8), 0);
    chk("rst_err",  32'(oerr8), 0);
    chk("rst_acc",  32'(acc8), 0);
    chk("rst_rdy",  32'(rdy8), 1);
    @(negedge clk); rst_n = 1'b1;

    // back-to-back single-cycle ops
    do1("add", 3'd0, 8'd200, 8'd100, 8'd44, 8'd0, 1'b0);
    do1("sub", 3'd1, 8'd5, 8'd7, 8'd254, 8'd0, 1'b0);
    do1("mul", 3'd2, 8'd16, 8'd17, 8'd16, 8'd0, 1'b0);

    // iterative divide: latency and ready-low window
    issue8(3'd3, 8'd200, 8'd7);
    lat = 1; low = 0;
    while (!ovld8 && lat < 40) begin
      if (!rdy8) low++;
      @(posedge clk); #1; lat++;
    end
    chk("div_lat",  32'(lat), 9);
    chk("div_rdy_low", 32'(low), 8);
    chk("div_q",    32'(odata8), 28);
    chk("div_r",    32'(orem8), 4);
    chk("div_err",  32'(oerr8), 0);
    do1("div0", 3'd3, 8'd5, 8'd0, 8'd255, 8'd5, 1'b1);

    // accumulator
    do1("clr", 3'd5, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    chk("clr_acc", 32'(acc8), 0);
    do1("mac1", 3'd4, 8'd3, 8'd4, 8'd12, 8'd0, 1'b0);
    chk("mac1_acc", 32'(acc8), 12);
    do1("mac2", 3'd4, 8'd10, 8'd10, 8'd112, 8'd0, 1'b0);
    chk("mac2_acc", 32'(acc8), 112);
    do1("mac3", 3'd4, 8'd12, 8'd12, 8'd0, 8'd0, 1'b0);
    chk("mac3_acc", 32'(acc8), 0);
    do1("mac4", 3'd4, 8'd3, 8'd4, 8'd12, 8'd0, 1'b0);
    do1("ill6", 3'd6, 8'd9, 8'd9, 8'd0, 8'd0, 1'b1);
    chk("ill6_acc", 32'(acc8), 12);
    do1("ill7", 3'd7, 8'd1, 8'd1, 8'd0, 8'd0, 1'b1);
    do1("add_acc", 3'd0, 8'd1, 8'd1, 8'd2, 8'd0, 1'b0);
    chk("add_acc_keep", 32'(acc8), 12);

    // back-pressure
    do1("bp_add", 3'd0, 8'd1, 8'd2, 8'd3, 8'd0, 1'b0);
    ordy8 = 1'b0; vld8 = 1'b1; op8 = 3'd0; a8 = 8'd9; b8 = 8'd9;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_vld",  32'(ovld8), 1);
      chk("bp_data", 32'(odata8), 3);
      chk("bp_rdy",  32'(rdy8), 0);
    end
    @(negedge clk); ordy8 = 1'b1; #1;
    chk("bp_rdy_rise", 32'(rdy8), 1);
    @(posedge clk); #1; vld8 = 1'b0;
    chk("bp_next_vld",  32'(ovld8), 1);
    chk("bp_next_data", 32'(odata8), 18);

    // reset in the middle of a divide
    do1("pre_mac", 3'd4, 8'd5, 8'd5, 8'd37, 8'd0, 1'b0);
    issue8(3'd3, 8'd200, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mid_rst_vld", 32'(ovld8), 0);
    chk("mid_rst_acc", 32'(acc8), 0);
    chk("mid_rst_rdy", 32'(rdy8), 1);
    @(negedge clk); rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (ovld8) stale++;
    end
    chk("no_stale", 32'(stale), 0);
    chk("post_rst_rdy", 32'(rdy8), 1);

    // WIDTH=32 random stream with random stalls
    m_acc = 0; n_res = 0; pend = 1'b0;
    for (int cyc = 0; cyc < 20000 && n_res < 250; cyc++) begin
      @(negedge clk);
      if (!pend) begin
        vld32 = ($urandom_range(0, 3) != 0);
        op32  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        a32   = $urandom >> $urandom_range(0, 31);
        b32   = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
        pend  = vld32;
      end
      ordy32 = ($urandom_range(0, 3) != 0);
      #1;
      if (ovld32 && ordy32) begin
        chk("r_avail", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          x = q.pop_front();
          chk("r_data", odata32, x.d);
          chk("r_rem",  orem32, x.r);
          chk("r_err",  32'(oerr32), 32'(x.e));
          chk("r_acc",  acc32, x.acc);
        end
        n_res++;
      end
      if (vld32 && rdy32) begin
        q.push_back(model(op32, a32, b32));
        pend = 1'b0;
      end
    end
    @(negedge clk); vld32 = 1'b0; ordy32 = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (ovld32) begin
        chk("d_avail", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          x = q.pop_front();
          chk("d_data", odata32, x.d);
          chk("d_rem",  orem32, x.r);
          chk("d_err",  32'(oerr32), 32'(x.e));
        end
      end
      @(negedge clk);
    end
    chk("lost", 32'(q.size()), 0);
    chk("rand_progress", 32'(n_res >= 250), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
